// File: rtl/prg_loader.sv
`timescale 1ns/1ps
// prg_loader: download engine between the data_io byte stream and a memory
// write port. PRG mode takes a 2-byte little-endian load address from the
// stream; raw mode loads at raw_base. Payload bytes go through a small FIFO
// and are written under a req/ack handshake. After the download, the final
// end address can be written into a list of zero-page pointer pairs.
// Optional build macro: PRG_LOADER_CHKSUM_EN adds the chksum output
// (modulo-256 sum of the payload bytes written).
module prg_loader #(
    parameter int                 AW       = 16,
    parameter int                 NPTR     = 4,
    parameter logic [NPTR*AW-1:0] PTR_LIST = {16'h00ae, 16'h0031, 16'h002f, 16'h002d},
    parameter int                 DEPTH    = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic          dl_mode,
    input  logic [AW-1:0] raw_base,
    input  logic          inject_en,
    input  logic          in_wr,
    input  logic [7:0]    in_data,
    output logic          out_wr,
    output logic [AW-1:0] out_addr,
    output logic [7:0]    out_data,
    input  logic          out_ack,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [AW-1:0] end_addr
`ifdef PRG_LOADER_CHKSUM_EN
    ,
    output logic [7:0]    chksum
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (NPTR > 1) ? $clog2(NPTR) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_DRAIN,
        ST_INJ,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            dl_prev_q;
    logic            inject_q, inject_d;
    logic [AW-1:0]   cur_q, cur_d;
    logic [AW-1:0]   end_q, end_d;
    logic            ovf_q, ovf_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            hi_q, hi_d;
`ifdef PRG_LOADER_CHKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    // FIFO storage and pointers
    logic [7:0]      fifo_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rd_base, wr_base;
    logic [CW-1:0]   cnt_base;
    logic            full_base;
    logic            push_req, push_ok;
    logic            pop, fifo_clr;
    logic            fifo_empty;
    logic [7:0]      fifo_head;
    logic            dl_rise;

    assign dl_rise    = dl_active && !dl_prev_q;
    assign push_req   = in_wr && dl_active;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_head  = fifo_q[rd_ptr_q];

    // Control FSM: header parse, payload writes, pointer injection, restart.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        inject_d = inject_q;
        cur_d    = cur_q;
        end_d    = end_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        pop      = 1'b0;
        fifo_clr = 1'b0;
`ifdef PRG_LOADER_CHKSUM_EN
        sum_d    = sum_q;
`endif

        case (state_q)
            ST_IDLE: begin
            end

            ST_HDR_LO: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cur_d      = '0;
                    cur_d[7:0] = fifo_head;
                    state_d    = ST_HDR_HI;
                end else if (!dl_active) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_HDR_HI: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    cur_d[15:8] = fifo_head;
                    state_d     = ST_DATA;
                end else if (!dl_active) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DATA, ST_DRAIN: begin
                if (wr_q) begin
                    if (out_ack) begin
                        wr_d  = 1'b0;
                        pop   = 1'b1;
                        cur_d = cur_q + AW'(1);
                        end_d = cur_q + AW'(1);
`ifdef PRG_LOADER_CHKSUM_EN
                        sum_d = sum_q + data_q;
`endif
                    end
                end else if (!fifo_empty) begin
                    wr_d   = 1'b1;
                    addr_d = cur_q;
                    data_d = fifo_head;
                end else if (state_q == ST_DRAIN) begin
                    state_d = (inject_q && (NPTR > 0)) ? ST_INJ : ST_DONE;
                end
                if ((state_q == ST_DATA) && !dl_active) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_INJ: begin
                if (wr_q) begin
                    if (out_ack) begin
                        wr_d = 1'b0;
                        if (hi_q) begin
                            hi_d = 1'b0;
                            if (idx_q == IW'(NPTR - 1)) begin
                                state_d = ST_DONE;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end else begin
                            hi_d = 1'b1;
                        end
                    end
                end else begin
                    wr_d   = 1'b1;
                    addr_d = PTR_LIST[int'(idx_q) * AW +: AW] + AW'(hi_q);
                    data_d = hi_q ? end_q[15:8] : end_q[7:0];
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new download start wins over everything, including an active
        // transfer: the pending request and buffered bytes are discarded.
        if (dl_rise) begin
            fifo_clr = 1'b1;
            pop      = 1'b0;
            wr_d     = 1'b0;
            idx_d    = '0;
            hi_d     = 1'b0;
            inject_d = inject_en;
            state_d  = dl_mode ? ST_DATA : ST_HDR_LO;
            cur_d    = dl_mode ? raw_base : '0;
            end_d    = dl_mode ? raw_base : '0;
`ifdef PRG_LOADER_CHKSUM_EN
            sum_d    = '0;
`endif
        end
    end

    // FIFO bookkeeping: clear on restart, push/pop, overflow on dropped byte.
    always_comb begin
        rd_base   = fifo_clr ? '0 : rd_ptr_q;
        wr_base   = fifo_clr ? '0 : wr_ptr_q;
        cnt_base  = fifo_clr ? '0 : cnt_q;
        full_base = (cnt_base == CW'(DEPTH));
        push_ok   = push_req && (!full_base || pop);
        rd_ptr_d  = rd_base + PW'(pop);
        wr_ptr_d  = wr_base + PW'(push_ok);
        cnt_d     = cnt_base + CW'(push_ok) - CW'(pop);
        ovf_d     = fifo_clr ? 1'b0 : ovf_q;
        if (push_req && full_base && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            dl_prev_q <= 1'b0;
            inject_q  <= 1'b0;
            cur_q     <= '0;
            end_q     <= '0;
            ovf_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            hi_q      <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
`ifdef PRG_LOADER_CHKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dl_prev_q <= dl_active;
            inject_q  <= inject_d;
            cur_q     <= cur_d;
            end_q     <= end_d;
            ovf_q     <= ovf_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            hi_q      <= hi_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
`ifdef PRG_LOADER_CHKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // FIFO byte storage.
    always_ff @(posedge clk_sys) begin
        // NOTE: the storage array has no reset; the count and pointers are
        // reset, so stale contents are never read.
        if (push_ok) begin
            fifo_q[wr_base] <= in_data;
        end
    end

    assign out_wr   = wr_q;
    assign out_addr = addr_q;
    assign out_data = data_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign overflow = ovf_q;
    assign end_addr = end_q;
`ifdef PRG_LOADER_CHKSUM_EN
    assign chksum   = sum_q;
`endif

endmodule

// File: tb/tb_prg_loader.sv
`timescale 1ns/1ps
// Self-checking bench for prg_loader: directed scenarios plus randomized
// downloads compared against a transaction-level reference model.
module tb_prg_loader;

    typedef logic [7:0] byte_q_t [$];
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    localparam logic [15:0] PTRS [4] = '{16'h002d, 16'h002f, 16'h0031, 16'h00ae};

    logic        clk_sys;
    logic        reset_n;
    logic        dl_active;
    logic        dl_mode;
    logic [15:0] raw_base;
    logic        inject_en;
    logic        in_wr;
    logic [7:0]  in_data;
    logic        out_wr;
    logic [15:0] out_addr;
    logic [7:0]  out_data;
    logic        out_ack;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] end_addr;
`ifdef PRG_LOADER_CHKSUM_EN
    logic [7:0]  chksum;
`endif

    prg_loader dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .dl_active (dl_active),
        .dl_mode   (dl_mode),
        .raw_base  (raw_base),
        .inject_en (inject_en),
        .in_wr     (in_wr),
        .in_data   (in_data),
        .out_wr    (out_wr),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .end_addr  (end_addr)
`ifdef PRG_LOADER_CHKSUM_EN
        ,
        .chksum    (chksum)
`endif
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  obs_q [$];
    wr_t  exp_q [$];
    int   done_cnt = 0;
    int   stab_err = 0;
    int   ack_delay = 0;
    int   ack_cnt = 0;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Memory-side responder: ack after ack_delay cycles, or tied high.
    initial begin
        out_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (ack_delay == 0) begin
                out_ack = 1'b1;
            end else if (!out_wr) begin
                out_ack = 1'b0;
                ack_cnt = 0;
            end else if (!out_ack) begin
                if (ack_cnt >= ack_delay) out_ack = 1'b1;
                else ack_cnt++;
            end
        end
    end

    // Observer on the falling edge: accepted writes, done pulses, stability.
    initial begin
        logic        prev_wr;
        logic        prev_ack;
        logic [15:0] prev_addr;
        logic [7:0]  prev_data;
        prev_wr = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk_sys);
            if (out_wr && out_ack) obs_q.push_back('{addr: out_addr, data: out_data});
            if (done) done_cnt++;
            if (out_wr && prev_wr && !prev_ack &&
                ((out_addr !== prev_addr) || (out_data !== prev_data))) stab_err++;
            prev_wr = out_wr;
            prev_ack = out_ack;
            prev_addr = out_addr;
            prev_data = out_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        done_cnt = 0;
        stab_err = 0;
    endtask

    // Reference model: the writes a complete download must produce.
    task automatic build_exp(input bit mode, input logic [15:0] base, input bit inj,
                             input byte_q_t s, output logic [15:0] e_end,
                             output logic [7:0] e_sum);
        logic [15:0] load;
        int first;
        int n;
        exp_q.delete();
        e_sum = 8'h00;
        if (mode) begin
            load = base;
            first = 0;
        end else begin
            load = (s.size() >= 2) ? {s[1], s[0]} : 16'h0000;
            first = 2;
        end
        n = (s.size() > first) ? s.size() - first : 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{addr: 16'(load + k), data: s[first + k]});
            e_sum = e_sum + s[first + k];
        end
        e_end = (mode || n > 0) ? 16'(load + n) : 16'h0000;
        if (inj) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back('{addr: PTRS[i], data: e_end[7:0]});
                exp_q.push_back('{addr: 16'(PTRS[i] + 1), data: e_end[15:8]});
            end
        end
    endtask

    task automatic start_dl(input bit mode, input logic [15:0] base, input bit inj);
        dl_mode = mode;
        raw_base = base;
        inject_en = inj;
        dl_active = 1'b1;
        step(1);
    endtask

    task automatic send_bytes(input byte_q_t s, input int gap);
        foreach (s[k]) begin
            in_wr = 1'b1;
            in_data = s[k];
            step(1);
            in_wr = 1'b0;
            step(gap);
        end
    endtask

    task automatic end_and_wait(input string tag);
        int t;
        dl_active = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            step(1);
            t++;
        end
        check({tag, " done_seen"}, 32'(done_cnt != 0), 32'd1);
        step(4);
    endtask

    task automatic compare_all(input string tag, input logic [15:0] e_end, input logic [7:0] e_sum);
        check({tag, " nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), obs_q[i].addr, exp_q[i].addr);
            check($sformatf("%s data%0d", tag, i), obs_q[i].data, exp_q[i].data);
        end
        check({tag, " end_addr"}, end_addr, e_end);
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " overflow"}, overflow, 1'b0);
        check({tag, " stable"}, stab_err, 0);
`ifdef PRG_LOADER_CHKSUM_EN
        check({tag, " chksum"}, chksum, e_sum);
`else
        if (e_sum == 8'h00 && e_sum != 8'h00) $display("unreachable");
`endif
    endtask

    task automatic run_dl(input string tag, input bit mode, input logic [15:0] base,
                          input bit inj, input byte_q_t s, input int gap);
        logic [15:0] e_end;
        logic [7:0]  e_sum;
        clear_obs();
        start_dl(mode, base, inj);
        send_bytes(s, gap);
        end_and_wait(tag);
        build_exp(mode, base, inj, s, e_end, e_sum);
        compare_all(tag, e_end, e_sum);
    endtask

    initial begin
        byte_q_t s;
        int t;
        int j;
        reset_n = 1'b0;
        dl_active = 1'b0;
        dl_mode = 1'b0;
        raw_base = '0;
        inject_en = 1'b0;
        in_wr = 1'b0;
        in_data = '0;

        // Reset state
        step(3);
        reset_n = 1'b1;
        step(2);
        check("rst out_wr", out_wr, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst overflow", overflow, 1'b0);
        check("rst end_addr", end_addr, 16'h0000);

        // PRG with injection, ack tied high
        ack_delay = 0;
        s = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        run_dl("prg_inj", 1'b0, 16'h0000, 1'b1, s, 2);

        // Raw mode, no injection
        ack_delay = 1;
        s = '{8'h11, 8'h22, 8'h33};
        run_dl("raw", 1'b1, 16'hA000, 1'b0, s, 3);

        // Header only: no payload, end_addr 0, injection of zeros
        ack_delay = 0;
        s = '{8'h01, 8'h10};
        run_dl("hdr_only", 1'b0, 16'h0000, 1'b1, s, 2);

        // Address wrap at top of memory
        ack_delay = 2;
        s = '{8'hFE, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
        run_dl("wrap", 1'b0, 16'h0000, 1'b0, s, 4);

        // Overflow: bytes every cycle, slow acks
        ack_delay = 5;
        clear_obs();
        s.delete();
        for (int k = 0; k < 8; k++) s.push_back(8'(8'h50 + k));
        start_dl(1'b1, 16'h4000, 1'b0);
        send_bytes(s, 0);
        end_and_wait("ovf");
        check("ovf flag", overflow, 1'b1);
        check("ovf dropped", 32'(obs_q.size() < 8), 32'd1);
        check("ovf kept_min", 32'(obs_q.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < obs_q.size(); k++)
            check($sformatf("ovf head%0d", k), obs_q[k].data, s[k]);
        j = 0;
        foreach (s[k]) if (j < obs_q.size() && obs_q[j].data == s[k]) j++;
        check("ovf subseq", j, obs_q.size());
        for (int k = 0; k < obs_q.size(); k++)
            check($sformatf("ovf addr%0d", k), obs_q[k].addr, 16'(16'h4000 + k));
        check("ovf end_addr", end_addr, 16'(16'h4000 + obs_q.size()));
        check("ovf stable", stab_err, 0);

        // Restart mid-DATA: pending write dropped, overflow cleared
        ack_delay = 8;
        clear_obs();
        start_dl(1'b0, 16'h0000, 1'b0);
        s = '{8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_bytes(s, 0);
        check("rst_mid overflow_set", overflow, 1'b1);
        check("rst_mid pending", out_wr, 1'b1);
        dl_active = 1'b0;
        step(1);
        ack_delay = 5;
        start_dl(1'b0, 16'h0000, 1'b0);
        check("rst_mid overflow_clr", overflow, 1'b0);
        s = '{8'h00, 8'h30, 8'hAA, 8'hBB, 8'hCC};
        send_bytes(s, 7);
        end_and_wait("restart");
        begin
            logic [15:0] e_end;
            logic [7:0]  e_sum;
            build_exp(1'b0, 16'h0000, 1'b0, s, e_end, e_sum);
            compare_all("restart", e_end, e_sum);
            check("restart sum_model", e_sum, 8'h31);
        end

        // Reset in the middle of a write: out_wr falls without a clock edge
        ack_delay = 8;
        clear_obs();
        start_dl(1'b1, 16'h5000, 1'b0);
        s = '{8'h77, 8'h88};
        send_bytes(s, 0);
        t = 0;
        while (!out_wr && t < 50) begin
            step(1);
            t++;
        end
        check("arst wr_seen", out_wr, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst out_wr", out_wr, 1'b0);
        check("arst busy", busy, 1'b0);
        dl_active = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(3);
        check("arst idle", busy, 1'b0);
        check("arst no_wr", obs_q.size(), 0);
        check("arst no_done", done_cnt, 0);

        // Randomized downloads
        for (int it = 0; it < 24; it++) begin
            bit          m;
            bit          inj;
            logic [15:0] base;
            int          len;
            m = 1'($urandom_range(0, 1));
            inj = 1'($urandom_range(0, 1));
            base = 16'($urandom);
            len = $urandom_range(0, 10);
            ack_delay = $urandom_range(0, 3);
            s.delete();
            for (int k = 0; k < len; k++) s.push_back(8'($urandom));
            run_dl($sformatf("rnd%0d", it), m, base, inj, s, ack_delay + 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Parametrised PRG/cartridge download engine between data_io (download byte stream) and the SDRAM/internal-memory write path.
- In PRG mode it parses the 2-byte little-endian load address. In raw mode it places data at a supplied base address.
- Buffers incoming bytes and issues memory writes under a req/ack handshake.
- After the download ends it optionally injects the computed end address into a configurable list of zero-page pointer pairs (BASIC start-of-variables, end-of-load, etc.).

Parameters:
- AW, 16, address width of target memory.
- NPTR, 4, number of 16-bit pointer pairs injected after download (0 disables injection).
- PTR_LIST, {16'h00ae,16'h0031,16'h002f,16'h002d}, packed NPTR*AW vector of pointer low-byte addresses; entry 0 in the LSBs.
- DEPTH, 4, input FIFO depth in bytes (power of two, ≥2).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dl_active  in  1  download in progress (ioctl_download & index match).
- dl_mode  in  1  sampled on dl_active rise: 0 = PRG with header, 1 = raw at raw_base.
- raw_base  in  AW  load address for raw mode.
- inject_en  in  1  sampled on dl_active rise: 1 = run pointer injection at end.
- in_wr  in  1  single-cycle strobe, in_data valid.
- in_data  in  8  download byte.
- out_wr  out  1  write request; held until out_ack.
- out_addr  out  AW  write address.
- out_data  out  8  write data.
- out_ack  in  1  write accepted; may be asserted in the same cycle out_wr rises.
- busy  out  1  high from dl_active rise until DONE.
- done  out  1  one-cycle pulse when all writes and injections are complete.
- overflow  out  1  sticky: byte received while FIFO full; cleared on next dl_active rise.
- end_addr  out  AW  load address + payload length (one past last byte).

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE.
- States and transitions:
  - IDLE: on dl_active rise, clear FIFO, overflow and byte counter; latch mode and inject_en. Go to HDR_LO (PRG) or DATA with cur = raw_base (raw).
  - HDR_LO / HDR_HI: consume header bytes from the FIFO into cur[7:0] / cur[15:8]. Header bytes are never written to memory. Upper AW-16 bits of cur are zero when AW > 16.
  - DATA: while the FIFO is non-empty, present the head byte at cur on out_wr. On out_ack, pop the byte and increment cur (wraps modulo 2^AW). When dl_active falls, go to DRAIN.
  - DRAIN: keep writing until the FIFO is empty. end_addr = cur. Go to INJ if inject_en && NPTR > 0, else DONE.
  - INJ: for i = 0..NPTR-1:
    - write end_addr[7:0] to PTR_LIST[i];
    - then write end_addr[15:8] to PTR_LIST[i]+1.
    - Each write uses the same req/ack handshake.
  - DONE: pulse done for one cycle, busy = 0, return to IDLE.
- Handshake: out_addr and out_data are stable while out_wr is high. The next request may start the cycle after the ack, so best-case throughput is 1 byte per 2 cycles.
- FIFO: push on in_wr. Simultaneous push and pop in the same cycle is legal when the FIFO is full. A push while full and not popping drops the byte and sets overflow.
- end_addr is updated continuously during DATA and is final in DRAIN.
- PRG download ending after fewer than 2 bytes: no data writes, end_addr = 0, injection still runs if enabled.
- dl_active rising while busy: abort the current transfer (drop the FIFO, drop any pending out_wr) and restart at IDLE-rise handling. No done pulse for the aborted transfer.
- in_wr while not dl_active: ignored.
- reset_n low mid-operation: out_wr drops immediately (asynchronous); the partial write sequence is not resumed.

Optional Feature:
- PRG_LOADER_CHKSUM_EN defined:
  - adds output chksum[7:0]: 8-bit modulo-256 sum of payload bytes actually written (header and injected bytes excluded);
  - cleared on dl_active rise; final when done pulses.
- Not defined: port absent, no checksum logic.

Test Plan:
- PRG mode, inject_en=1, stream 01 10 AA BB CC, out_ack tied 1 -> writes 1001=AA, 1002=BB, 1003=CC; end_addr=1004; then 2D=04, 2E=10, 2F=04, 30=10, 31=04, 32=10, AE=04, AF=10; one done pulse.
- Raw mode, raw_base=A000, 3 bytes 11 22 33, inject_en=0 -> writes A000..A002, end_addr=A003, no injection writes, done pulse.
- out_ack delayed 5 cycles per write, bytes every cycle (DEPTH=4), 6 bytes -> overflow=1, only the dropped bytes missing; out_addr/out_data stable while out_wr is high.
- PRG header only (01 10), dl_active falls -> no data writes, end_addr=0, injection writes 00 to all 8 pointer bytes.
- Load at FFFE with 4 bytes -> addresses FFFE, FFFF, 0000, 0001; end_addr=0002.
- Restart (dl_active re-rises) mid-DATA -> pending write dropped, new load address used, overflow cleared; with PRG_LOADER_CHKSUM_EN, payload AA BB CC -> chksum=31.
